// File: rtl/hdmi_pattern_pkg.sv
// Shared definitions for the HDMI test-pattern generator: mode encodings,
// the colour-bar palette and the 8-bit to COLOR_W channel widening helper.
package hdmi_pattern_pkg;

  typedef enum logic [2:0] {
    MODE_XOR      = 3'd0,
    MODE_BARS     = 3'd1,
    MODE_CHECKER  = 3'd2,
    MODE_GRADIENT = 3'd3,
    MODE_BORDER   = 3'd4
  } mode_e;

  localparam int unsigned COLOR_MAX_W = 12;

  localparam logic [23:0] COLOR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COLOR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COLOR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COLOR_GREEN   = 24'h00FF00;
  localparam logic [23:0] COLOR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COLOR_RED     = 24'hFF0000;
  localparam logic [23:0] COLOR_BLUE    = 24'h0000FF;
  localparam logic [23:0] COLOR_BLACK   = 24'h000000;

  // Index 0 is the leftmost bar.
  localparam logic [7:0][23:0] BAR_COLORS = {
    COLOR_BLACK, COLOR_BLUE, COLOR_RED, COLOR_MAGENTA,
    COLOR_GREEN, COLOR_CYAN, COLOR_YELLOW, COLOR_WHITE
  };

  // Left-aligns an 8-bit channel into color_w bits; caller keeps the low color_w bits.
  function automatic logic [COLOR_MAX_W-1:0] expand_chan(input logic [7:0] v,
                                                         input int unsigned color_w);
    logic [COLOR_MAX_W-1:0] w;
    w = {4'b0000, v};
    return w << (color_w - 8);
  endfunction

endpackage

// File: rtl/hdmi_pattern_gen_btn_debounce.sv
// Front-panel button conditioning: 2-flop synchroniser, stable-time debouncer
// and a one-clock pulse on each debounced rising edge.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 742500
) (
  input  logic clk_pixel,
  input  logic rst,
  input  logic btn_async,
  output logic btn_rise
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned and infers a latch.
    sync_d  = {sync_q[0], btn_async};
    level_d = level_q;
    cnt_d   = '0;
    // Count consecutive samples that disagree with the debounced level.
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge clk_pixel) begin
    // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
    if (rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  assign btn_rise = rise_q;

endmodule

// File: rtl/hdmi_pattern_gen.sv
// Multi-mode HDMI test-pattern generator: frame-synchronous mode control plus
// a two-stage pixel pipeline from (cx, cy) to rgb.
module hdmi_pattern_gen
  import hdmi_pattern_pkg::*;
#(
  parameter int unsigned COORD_W         = 11,
  parameter int unsigned COLOR_W         = 8,
  parameter int unsigned SCREEN_W        = 1280,
  parameter int unsigned SCREEN_H        = 720,
  parameter int unsigned FRAME_W         = 1650,
  parameter int unsigned FRAME_H         = 750,
  parameter int unsigned DEBOUNCE_CYCLES = 742500
) (
  input  logic                 clk_pixel,
  input  logic                 rst,
  input  logic                 btn_next,
  input  logic                 mode_sel_en,
  input  logic [2:0]           mode_sel,
  input  logic [COORD_W-1:0]   cx,
  input  logic [COORD_W-1:0]   cy,
  output logic [3*COLOR_W-1:0] rgb,
  output logic [2:0]           mode,
  output logic [7:0]           frame_cnt
);

  typedef struct packed {
    logic [COORD_W-1:0] cx;
    logic [COORD_W-1:0] cy;
    logic [2:0]         mode;
    logic [7:0]         frame;
    logic               active;
  } stage1_t;

  logic                 btn_rise;
  logic                 boundary;
  logic [2:0]           mode_q, mode_d;
  logic [7:0]           frame_cnt_q, frame_cnt_d;
  logic                 pending_q, pending_d;
  stage1_t              s1_q, s1_d;
  logic [3*COLOR_W-1:0] rgb_q, rgb_d;
  logic [23:0]          p8;
  logic [2:0]           bar_k;
  logic [7:0]           xor8;
  logic                 on_border;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk_pixel(clk_pixel),
    .rst      (rst),
    .btn_async(btn_next),
    .btn_rise (btn_rise)
  );

  assign boundary = (cx == COORD_W'(FRAME_W - 1)) && (cy == COORD_W'(FRAME_H - 1));

  always_comb begin
    mode_d      = mode_q;
    frame_cnt_d = frame_cnt_q;
    pending_d   = pending_q | btn_rise;
    if (boundary) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
      if (mode_sel_en) begin
        mode_d = mode_sel;
      end else if (pending_q) begin
        mode_d = (mode_q >= MODE_BORDER) ? MODE_XOR : mode_q + 3'd1;
      end
      // A press landing on the boundary clock carries over to the next frame.
      pending_d = btn_rise;
    end
  end

  always_comb begin
    s1_d.cx     = cx;
    s1_d.cy     = cy;
    s1_d.mode   = mode_q;
    s1_d.frame  = frame_cnt_q;
    s1_d.active = (cx < COORD_W'(SCREEN_W)) && (cy < COORD_W'(SCREEN_H));
  end

  always_comb begin
    bar_k = '0;
    for (int j = 1; j < 8; j++) begin
      if (32'(s1_q.cx) >= 32'(j * (SCREEN_W / 8))) bar_k = bar_k + 3'd1;
    end
    xor8      = s1_q.cx[7:0] ^ s1_q.cy[7:0];
    on_border = (s1_q.cx == '0) || (s1_q.cy == '0) ||
                (s1_q.cx == COORD_W'(SCREEN_W - 1)) || (s1_q.cy == COORD_W'(SCREEN_H - 1));

    p8 = '0;
    case (s1_q.mode)
      MODE_XOR:      p8 = {xor8, xor8, xor8};
      MODE_BARS:     p8 = BAR_COLORS[bar_k];
      MODE_CHECKER:  p8 = (s1_q.cx[5] ^ s1_q.cy[5]) ? COLOR_WHITE : COLOR_BLACK;
      MODE_GRADIENT: p8 = {s1_q.cx[7:0] + s1_q.frame, s1_q.cy[7:0], s1_q.frame};
      MODE_BORDER:   p8 = on_border ? COLOR_WHITE : COLOR_BLACK;
      default:       p8 = COLOR_BLACK;
    endcase

    rgb_d = '0;
    if (s1_q.active) begin
      rgb_d = {COLOR_W'(expand_chan(p8[23:16], COLOR_W)),
               COLOR_W'(expand_chan(p8[15:8],  COLOR_W)),
               COLOR_W'(expand_chan(p8[7:0],   COLOR_W))};
    end
  end

  always_ff @(posedge clk_pixel) begin
    // NOTE: pipeline registers are reset too, so rgb stays black until real pixels reach stage 2.
    if (rst) begin
      mode_q      <= '0;
      frame_cnt_q <= '0;
      pending_q   <= 1'b0;
      s1_q        <= '0;
      rgb_q       <= '0;
    end else begin
      mode_q      <= mode_d;
      frame_cnt_q <= frame_cnt_d;
      pending_q   <= pending_d;
      s1_q        <= s1_d;
      rgb_q       <= rgb_d;
    end
  end

  assign rgb       = rgb_q;
  assign mode      = mode_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// Randomised bench for hdmi_pattern_gen: two DUTs (8- and 10-bit colour) share
// stimulus and are compared every cycle against a pixel-level behavioural model.
module tb_hdmi_pattern_gen;

  localparam int DEB = 16;
  localparam int FW  = 1650;
  localparam int FH  = 750;
  localparam int SW  = 1280;
  localparam int SH  = 720;

  logic        clk_pixel = 1'b0;
  logic        rst = 1'b1;
  logic        btn_next = 1'b0;
  logic        mode_sel_en = 1'b0;
  logic [2:0]  mode_sel = 3'd0;
  logic [10:0] cx = '0;
  logic [10:0] cy = '0;

  logic [23:0] rgb8;
  logic [29:0] rgb10;
  logic [2:0]  mode8, mode10;
  logic [7:0]  frame8, frame10;

  always #5 clk_pixel = ~clk_pixel;

  hdmi_pattern_gen #(.COLOR_W(8), .DEBOUNCE_CYCLES(DEB)) dut8 (
    .clk_pixel(clk_pixel), .rst(rst), .btn_next(btn_next),
    .mode_sel_en(mode_sel_en), .mode_sel(mode_sel), .cx(cx), .cy(cy),
    .rgb(rgb8), .mode(mode8), .frame_cnt(frame8)
  );

  hdmi_pattern_gen #(.COLOR_W(10), .DEBOUNCE_CYCLES(DEB)) dut10 (
    .clk_pixel(clk_pixel), .rst(rst), .btn_next(btn_next),
    .mode_sel_en(mode_sel_en), .mode_sel(mode_sel), .cx(cx), .cy(cy),
    .rgb(rgb10), .mode(mode10), .frame_cnt(frame10)
  );

  int  n_chk = 0;
  int  n_err = 0;
  bit  chk_en = 1'b0;

  // Behavioural model state.
  int          m_mode = 0;
  int          m_frame = 0;
  bit          m_pend = 1'b0;
  logic [23:0] m_p1 = '0;
  logic [23:0] m_out = '0;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] pix(input int x, input int y, input int md, input int fc);
    int v;
    if (x >= SW || y >= SH) return 24'h0;
    case (md)
      0: begin
        v = (x ^ y) & 255;
        return {8'(v), 8'(v), 8'(v)};
      end
      1: return bars[x / (SW / 8)];
      2: return ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h0;
      3: return {8'((x + fc) & 255), 8'(y & 255), 8'(fc)};
      4: return (x == 0 || y == 0 || x == SW - 1 || y == SH - 1) ? 24'hFFFFFF : 24'h0;
      default: return 24'h0;
    endcase
  endfunction

  function automatic logic [29:0] widen10(input logic [23:0] p);
    return {p[23:16], 2'b00, p[15:8], 2'b00, p[7:0], 2'b00};
  endfunction

  // Effect of one rising clock edge on the model, from the inputs held across it.
  task automatic model_edge();
    if (rst) begin
      m_mode = 0; m_frame = 0; m_pend = 1'b0; m_p1 = '0; m_out = '0;
    end else begin
      m_out = m_p1;
      m_p1  = pix(int'(cx), int'(cy), m_mode, m_frame);
      if (int'(cx) == FW - 1 && int'(cy) == FH - 1) begin
        m_frame = (m_frame + 1) % 256;
        if (mode_sel_en) m_mode = int'(mode_sel);
        else if (m_pend) m_mode = (m_mode >= 4) ? 0 : m_mode + 1;
        m_pend = 1'b0;
      end
    end
  endtask

  always @(negedge clk_pixel) begin
    if (chk_en) begin
      check("rgb8",    rgb8,    m_out);
      check("rgb10",   rgb10,   widen10(m_out));
      check("mode8",   mode8,   m_mode);
      check("mode10",  mode10,  m_mode);
      check("frame8",  frame8,  m_frame);
      check("frame10", frame10, m_frame);
    end
  end

  task automatic tick();
    @(posedge clk_pixel);
    model_edge();
    @(negedge clk_pixel);
  endtask

  task automatic set_px(input int x, input int y);
    cx = 11'(x);
    cy = 11'(y);
  endtask

  task automatic show(input int x, input int y);
    set_px(x, y);
    tick();
    tick();
  endtask

  task automatic rand_tick();
    cx = 11'($urandom_range(FW - 1));
    cy = 11'($urandom_range(FH - 1));
    if (int'(cx) == FW - 1 && int'(cy) == FH - 1) cy = '0;
    tick();
  endtask

  task automatic boundary();
    set_px(FW - 1, FH - 1);
    tick();
  endtask

  task automatic override_at_boundary(input int md);
    mode_sel_en = 1'b1;
    mode_sel    = 3'(md);
    rand_tick();
    boundary();
    mode_sel_en = 1'b0;
  endtask

  task automatic btn_run(input logic lvl, input int n);
    btn_next = lvl;
    repeat (n) rand_tick();
  endtask

  // Glitches all shorter than the debounce time.
  task automatic bounce_only();
    repeat (5) begin
      btn_run(1'b1, $urandom_range(1, 10));
      btn_run(1'b0, $urandom_range(1, 5));
    end
    btn_run(1'b0, DEB + 8);
  endtask

  // A bouncy press that then settles high long enough to register once.
  task automatic press();
    repeat (3) begin
      btn_run(1'b1, $urandom_range(1, 10));
      btn_run(1'b0, $urandom_range(1, 4));
    end
    btn_run(1'b1, DEB + 8);
    m_pend = 1'b1;
    btn_run(1'b0, 2);
    btn_run(1'b1, 3);
    btn_run(1'b0, DEB + 8);
  endtask

  initial begin
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;

    show(3, 5);
    check("xor_3_5_rgb8",  rgb8,  24'h060606);
    check("xor_3_5_rgb10", rgb10, {10'h018, 10'h018, 10'h018});
    check("reset_mode",    mode8, 0);
    check("reset_frame",   frame8, 0);

    mode_sel_en = 1'b1;
    mode_sel    = 3'd1;
    set_px(500, 300);
    repeat (5) tick();
    check("override_held_midframe", mode8, 0);
    boundary();
    mode_sel_en = 1'b0;
    check("override_at_boundary", mode8, 1);
    check("frame_after_boundary", frame8, 1);
    show(200, 10);
    check("bars_200", rgb8, 24'hFFFF00);
    show(1279, 10);
    check("bars_1279", rgb8, 24'h000000);
    show(159, 10);
    check("bars_159", rgb8, 24'hFFFFFF);
    show(160, 10);
    check("bars_160", rgb8, 24'hFFFF00);

    bounce_only();
    boundary();
    check("bounce_no_advance", mode8, 1);

    override_at_boundary(0);
    for (int i = 0; i < 5; i++) begin
      press();
      boundary();
      check("btn_advance", mode8, (i + 1) % 5);
    end

    override_at_boundary(6);
    show(100, 100);
    check("mode6_black", rgb8, 24'h0);
    press();
    boundary();
    check("mode6_wraps_to_0", mode8, 0);

    override_at_boundary(3);
    while (m_frame != 10) begin
      rand_tick();
      boundary();
    end
    show(250, 7);
    check("gradient_250_7", rgb8, 24'h04070A);
    for (int i = 0; i < 256; i++) begin
      rand_tick();
      boundary();
      if (i == 245) check("frame_wrap_to_0", frame8, 0);
    end
    check("frame_after_256", frame8, 10);

    override_at_boundary(4);
    show(0, 100);
    check("border_0_100", rgb8, 24'hFFFFFF);
    show(1, 100);
    check("border_1_100", rgb8, 24'h0);
    show(1279, 5);
    check("border_right", rgb8, 24'hFFFFFF);
    show(1300, 100);
    check("blank_x", rgb8, 24'h0);
    show(100, 730);
    check("blank_y", rgb8, 24'h0);

    repeat (2000) begin
      mode_sel_en = ($urandom_range(0, 3) == 0);
      mode_sel    = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) begin
        boundary();
      end else if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) set_px($urandom_range(SW, FW - 1), $urandom_range(0, FH - 1));
        else                           set_px($urandom_range(0, FW - 1), $urandom_range(SH, FH - 1));
        tick();
      end else begin
        rand_tick();
      end
    end
    mode_sel_en = 1'b0;

    override_at_boundary(2);
    set_px(600, 200);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("rst_mode",  mode8,  0);
    check("rst_frame", frame8, 0);
    check("rst_rgb",   rgb8,   24'h0);
    rst = 1'b0;
    override_at_boundary(2);
    show(32, 1);
    check("checker_white_rgb8",  rgb8,  24'hFFFFFF);
    check("checker_white_rgb10", rgb10, {10'h3FC, 10'h3FC, 10'h3FC});

    repeat (4) rand_tick();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hdmi_pattern_gen.md
# hdmi_pattern_gen

Parametrised multi-mode test-pattern generator for the HDMI/DVI output path. It sits between the `hdmi` core's pixel-position outputs (`cx`, `cy`) and its `rgb` input, in the `clk_pixel` domain. It supersedes the fixed XOR pattern with five selectable patterns, a frame counter for animated output, and two mode-selection paths: a debounced front-panel button and a register-style override. Mode changes take effect only on frame boundaries.

## Interface
Parameters:
- `COORD_W`, 11: width of `cx`/`cy`; must hold `FRAME_W-1` and `FRAME_H-1`.
- `COLOR_W`, 8: bits per colour channel; legal range 8..12.
- `SCREEN_W`, 1280: active pixels per line; must be divisible by 8.
- `SCREEN_H`, 720: active lines.
- `FRAME_W`, 1650: total pixels per line, including blanking.
- `FRAME_H`, 750: total lines, including blanking.
- `DEBOUNCE_CYCLES`, 742500: button stable time in clocks (10 ms at 74.25 MHz).

Ports:
- `clk_pixel`, in, 1: pixel clock; the only clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `btn_next`, in, 1: raw asynchronous button; advances the mode.
- `mode_sel_en`, in, 1: enables the override; synchronous to `clk_pixel`.
- `mode_sel`, in, 3: override mode value.
- `cx`, in, `COORD_W`: current x position from the `hdmi` core.
- `cy`, in, `COORD_W`: current y position from the `hdmi` core.
- `rgb`, out, `3*COLOR_W`: pixel output as {R,G,B}.
- `mode`, out, 3: currently active mode.
- `frame_cnt`, out, 8: frame counter.

## Operation
- **Button path.**
  - `btn_next` passes through a 2-flop synchroniser, then a debouncer.
  - The debounced level changes only after the synchronised input has been stable for `DEBOUNCE_CYCLES` consecutive clocks.
  - A debounced rising edge sets a `pending_next` flag.
- **Frame boundary.** A clock on which `cx==FRAME_W-1 && cy==FRAME_H-1`. On that clock:
  - `frame_cnt` increments, wrapping 255→0.
  - If `mode_sel_en`=1: `mode` ← `mode_sel`. The flag `pending_next` is cleared.
  - Else if `pending_next`=1: `mode` ← `mode`+1, with 4→0 wrap; any value ≥4 also goes to 0. `pending_next` is cleared.
  - A debounced edge arriving on the boundary clock itself sets `pending_next` for the next frame.
- **Patterns.** Computed at 8 bits per channel (p8), then left-aligned to `COLOR_W` with zero-filled LSBs.
  - 0, XOR: R=G=B=(cx^cy)[7:0].
  - 1, colour bars: bar index k = number of constants j·SCREEN_W/8 (j=1..7) that are ≤ cx. Colours for k=0..7: white, yellow, cyan, green, magenta, red, blue, black. Each channel is FF or 00.
  - 2, checkerboard: white if (cx[5]^cy[5]), otherwise black.
  - 3, moving gradient: R=cx[7:0]+frame_cnt (mod 256), G=cy[7:0], B=frame_cnt.
  - 4, border: white where cx==0, cy==0, cx==SCREEN_W-1 or cy==SCREEN_H-1; black elsewhere.
  - 5..7: black.
- **Blanking.** `rgb`=0 whenever cx≥SCREEN_W or cy≥SCREEN_H, in every mode.

## Timing
- `rgb` latency: 2 clocks from `cx`/`cy`.
  - Stage 1 registers cx, cy, mode, frame_cnt, and the active flag.
  - Stage 2 registers `rgb`.
- `mode` and `frame_cnt` change one clock after the boundary clock. Pixel (0,0) of the next frame is rendered with the new mode and count.
- Reset values: `rgb`=0, `mode`=0, `frame_cnt`=0, `pending_next`=0, debounced level 0, debounce counter 0, pipeline registers 0.
- Reset asserted mid-frame: all of the above are reached on the first clock edge with `rst`=1. The first valid `rgb` appears 2 clocks after `rst` deasserts.
- The button press-to-mode-change delay is at least `DEBOUNCE_CYCLES`+2 clocks and at most that value plus one frame.

## Structure
- Package `hdmi_pattern_pkg` holds:
  - mode encodings (MODE_XOR..MODE_BORDER);
  - the 8-entry colour-bar constant table (24-bit, 8 bits per channel);
  - the 8→`COLOR_W` expansion function.
- Sub-module `btn_debounce` contains the synchroniser, the stable counter (width = clog2(DEBOUNCE_CYCLES+1)) and rising-edge pulse generation. It takes `DEBOUNCE_CYCLES` as a parameter.

## Test plan
- Reset, then mode 0, drive cx=3, cy=5 → rgb=0x060606 two clocks later; `mode`=0, `frame_cnt`=0.
- `mode_sel_en`=1, `mode_sel`=1 asserted mid-frame → `mode` stays 0 until one clock after (1649,749). Then cx=200, cy=10 → rgb=0xFFFF00; cx=1279 → 0x000000.
- Button pulses shorter than `DEBOUNCE_CYCLES` (run with DEBOUNCE_CYCLES=16, bounces of 10 clocks) → no mode change. One held press → exactly one advance per press, sequence 0→1→2→3→4→0.
- Mode 3, run 256 frames → `frame_cnt` wraps 255→0. At frame_cnt=10, cx=250, cy=7 → rgb=0x04070A.
- Blanking: any mode, cx=1300 or cy=730 → rgb=0. Mode 4, cx=0, cy=100 → 0xFFFFFF; cx=1, cy=100 → 0.
- Assert `rst` during mode 2 at cx=600 → next clock `mode`=0, `frame_cnt`=0, `rgb`=0. With COLOR_W=10, mode 2 white → rgb=30'h3FC_3FC_3FC.
